// File: rtl/mul_float_arbiter.sv
// Round-robin arbiter sharing one FP multiplier pipeline between four requesters.
// Winning operands go through a single issue register. The winner's ID is queued
// in an in-order tag FIFO so each returning result can be routed back to the
// requester that issued it.
module mul_float_arbiter #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       iCLOCK,
  input  logic                       inRESET,
  input  logic                       iRESET_SYNC,
  // Requester side
  input  logic [3:0]                 iREQ_VALID,
  output logic [3:0]                 oREQ_BUSY,
  input  logic [127:0]               iREQ_A,
  input  logic [127:0]               iREQ_B,
  // Multiplier input side
  output logic                       oMUL_VALID,
  input  logic                       iMUL_BUSY,
  output logic [31:0]                oMUL_A,
  output logic [31:0]                oMUL_B,
  // Multiplier output side
  input  logic                       iMUL_VALID,
  output logic                       oMUL_BUSY,
  input  logic [31:0]                iMUL_DATA,
  // Result side
  output logic [3:0]                 oRES_VALID,
  input  logic [3:0]                 iRES_BUSY,
  output logic [31:0]                oRES_DATA,
  // Status
  output logic [$clog2(DEPTH+1)-1:0] oINFLIGHT,
  output logic                       oERR
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Issue register
  logic             issue_valid_q, issue_valid_d;
  logic [31:0]      issue_a_q, issue_a_d;
  logic [31:0]      issue_b_q, issue_b_d;

  // Arbitration state
  logic [1:0]       rr_ptr_q, rr_ptr_d;

  // Tag FIFO; pointers carry one extra wrap bit
  logic [1:0]       tag_mem_q [DEPTH];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;

  logic [CntW-1:0]  inflight_q, inflight_d;
  logic             err_q, err_d;

  // Combinational control
  logic             issue_ready;
  logic             credit_ok;
  logic             grant_en;
  logic             found;
  logic [1:0]       cand;
  logic [1:0]       winner;
  logic             grant;
  logic             fifo_empty;
  logic [1:0]       head;
  logic             result_ok;
  logic             pop;
  logic             stray;

  // Round-robin winner search and requester stall generation
  always_comb begin
    issue_ready = !issue_valid_q || !iMUL_BUSY;
    credit_ok   = inflight_q < CntW'(DEPTH);
    grant_en    = issue_ready && credit_ok && !iRESET_SYNC;
    found       = 1'b0;
    cand        = 2'd0;
    winner      = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!found && iREQ_VALID[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    grant     = grant_en && found;
    oREQ_BUSY = 4'hF;
    if (grant) begin
      oREQ_BUSY[winner] = 1'b0;
    end
  end

  // Return routing: FIFO head tag steers the result to its requester
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    head       = tag_mem_q[rd_ptr_q[PtrW-1:0]];
    // A result with no outstanding tag is dropped and flagged
    result_ok  = iMUL_VALID && !fifo_empty && !iRESET_SYNC;
    stray      = iMUL_VALID && fifo_empty;
    oRES_VALID = 4'b0000;
    oMUL_BUSY  = 1'b0;
    pop        = 1'b0;
    if (result_ok) begin
      oRES_VALID[head] = 1'b1;
      oMUL_BUSY        = iRES_BUSY[head];
      pop              = !iRES_BUSY[head];
    end
    oRES_DATA = iMUL_DATA;
  end

  // Next-state for issue register, pointers, credit counter and error flag
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_a_d     = issue_a_q;
    issue_b_d     = issue_b_q;
    rr_ptr_d      = rr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inflight_d    = inflight_q;
    err_d         = err_q;

    if (iRESET_SYNC) begin
      issue_valid_d = 1'b0;
      issue_a_d     = 32'h0;
      issue_b_d     = 32'h0;
      rr_ptr_d      = 2'd0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      inflight_d    = '0;
      err_d         = 1'b0;
    end else begin
      if (grant) begin
        issue_valid_d = 1'b1;
        issue_a_d     = iREQ_A[{winner, 5'd0} +: 32];
        issue_b_d     = iREQ_B[{winner, 5'd0} +: 32];
        rr_ptr_d      = winner + 2'd1;
        wr_ptr_d      = wr_ptr_q + 1'b1;
      end else if (!iMUL_BUSY) begin
        issue_valid_d = 1'b0;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({grant, pop})
        2'b10:   inflight_d = inflight_q + CntW'(1);
        2'b01:   inflight_d = inflight_q - CntW'(1);
        default: inflight_d = inflight_q;
      endcase

      if (stray) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      issue_valid_q <= 1'b0;
      issue_a_q     <= 32'h0;
      issue_b_q     <= 32'h0;
      rr_ptr_q      <= 2'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inflight_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_a_q     <= issue_a_d;
      issue_b_q     <= issue_b_d;
      rr_ptr_q      <= rr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inflight_q    <= inflight_d;
      err_q         <= err_d;
    end
  end

  // Tag storage; entries are only read while the FIFO is non-empty
  always_ff @(posedge iCLOCK) begin
    if (grant) begin
      tag_mem_q[wr_ptr_q[PtrW-1:0]] <= winner;
    end
  end

  assign oMUL_VALID = issue_valid_q;
  assign oMUL_A     = issue_a_q;
  assign oMUL_B     = issue_b_q;
  assign oINFLIGHT  = inflight_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_mul_float_arbiter.sv
// Directed bench for mul_float_arbiter with a scoreboard of issued and returning ops.
module tb_mul_float_arbiter;

  localparam int unsigned DEPTH = 8;

  logic         iCLOCK = 1'b0;
  logic         inRESET;
  logic         iRESET_SYNC;
  logic [3:0]   iREQ_VALID;
  logic [3:0]   oREQ_BUSY;
  logic [127:0] iREQ_A;
  logic [127:0] iREQ_B;
  logic         oMUL_VALID;
  logic         iMUL_BUSY;
  logic [31:0]  oMUL_A;
  logic [31:0]  oMUL_B;
  logic         iMUL_VALID;
  logic         oMUL_BUSY;
  logic [31:0]  iMUL_DATA;
  logic [3:0]   oRES_VALID;
  logic [3:0]   iRES_BUSY;
  logic [31:0]  oRES_DATA;
  logic [3:0]   oINFLIGHT;
  logic         oERR;

  mul_float_arbiter #(.DEPTH(DEPTH)) dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iREQ_VALID  (iREQ_VALID),
    .oREQ_BUSY   (oREQ_BUSY),
    .iREQ_A      (iREQ_A),
    .iREQ_B      (iREQ_B),
    .oMUL_VALID  (oMUL_VALID),
    .iMUL_BUSY   (iMUL_BUSY),
    .oMUL_A      (oMUL_A),
    .oMUL_B      (oMUL_B),
    .iMUL_VALID  (iMUL_VALID),
    .oMUL_BUSY   (oMUL_BUSY),
    .iMUL_DATA   (iMUL_DATA),
    .oRES_VALID  (oRES_VALID),
    .iRES_BUSY   (iRES_BUSY),
    .oRES_DATA   (oRES_DATA),
    .oINFLIGHT   (oINFLIGHT),
    .oERR        (oERR)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } op_t;

  op_t         mul_pipe [$];  // ops accepted by the multiplier, awaiting return
  op_t         iss;           // op expected in the issue register
  bit          iss_v;
  int          exp_inflight;
  bit          exp_err;
  bit          fixed_ops;
  int          step;
  logic [31:0] req_a [4];
  logic [31:0] req_b [4];
  int          n_checks;
  int          n_fail;

  // Toy multiplier: 1.0 * x = x, otherwise a scrambled value that is unique per op
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000) return b;
    return a ^ b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  // One clock cycle: drive inputs, check outputs against the scoreboard, advance.
  // win is the requester expected to be granted this cycle, -1 for no grant.
  task automatic cycle(input logic [3:0] req, input int win, input bit ret, input bit mbusy,
                       input logic [3:0] rbusy);
    op_t        e;
    bit         popd;
    logic [3:0] exp_busy;
    step++;
    if (!fixed_ops) begin
      for (int i = 0; i < 4; i++) begin
        req_a[i] = 32'(32'h1000_0000 * (i + 1) + step);
        req_b[i] = 32'(32'h0001_0000 * (i + 1) + step * 3);
      end
    end
    for (int i = 0; i < 4; i++) begin
      iREQ_A[32*i +: 32] = req_a[i];
      iREQ_B[32*i +: 32] = req_b[i];
    end
    iREQ_VALID = req;
    iMUL_BUSY  = mbusy;
    iRES_BUSY  = rbusy;
    iMUL_VALID = ret && (mul_pipe.size() > 0);
    iMUL_DATA  = iMUL_VALID ? mul_pipe[0].res : 32'h0;
    #1;
    exp_busy = (win >= 0) ? ~(4'b0001 << win) : 4'hF;
    check("req_busy", oREQ_BUSY, exp_busy);
    check("mul_valid", oMUL_VALID, iss_v);
    if (iss_v) begin
      check("mul_a", oMUL_A, iss.a);
      check("mul_b", oMUL_B, iss.b);
    end
    popd = 1'b0;
    if (iMUL_VALID) begin
      e = mul_pipe[0];
      check("res_valid", oRES_VALID, 4'b0001 << e.id);
      check("res_data", oRES_DATA, e.res);
      check("mul_busy", oMUL_BUSY, rbusy[e.id]);
      if (!rbusy[e.id]) begin
        popd = 1'b1;
        void'(mul_pipe.pop_front());
      end
    end else begin
      check("res_valid_idle", oRES_VALID, 4'b0000);
    end
    check("inflight", oINFLIGHT, exp_inflight);
    check("err", oERR, exp_err);
    if (iss_v && !mbusy) begin
      mul_pipe.push_back(iss);
      iss_v = 1'b0;
    end
    if (win >= 0) begin
      iss.id  = 2'(win);
      iss.a   = req_a[win];
      iss.b   = req_b[win];
      iss.res = mul_model(req_a[win], req_b[win]);
      iss_v   = 1'b1;
    end
    exp_inflight = exp_inflight + ((win >= 0) ? 1 : 0) - (popd ? 1 : 0);
    tick();
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    step         = 0;
    iss_v        = 1'b0;
    iss          = '0;
    exp_inflight = 0;
    exp_err      = 1'b0;
    fixed_ops    = 1'b0;
    inRESET      = 1'b0;
    iRESET_SYNC  = 1'b0;
    iREQ_VALID   = 4'h0;
    iREQ_A       = '0;
    iREQ_B       = '0;
    iMUL_BUSY    = 1'b0;
    iMUL_VALID   = 1'b0;
    iMUL_DATA    = 32'h0;
    iRES_BUSY    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 32'h0;
      req_b[i] = 32'h0;
    end

    // Reset state
    tick();
    tick();
    inRESET = 1'b1;
    #1;
    check("rst_mul_valid", oMUL_VALID, 1'b0);
    check("rst_mul_a", oMUL_A, 32'h0);
    check("rst_mul_b", oMUL_B, 32'h0);
    check("rst_res_valid", oRES_VALID, 4'h0);
    check("rst_inflight", oINFLIGHT, 0);
    check("rst_err", oERR, 1'b0);
    check("rst_req_busy", oREQ_BUSY, 4'hF);
    tick();

    // Round robin with all requesters active until the credit limit is reached
    for (int k = 0; k < 8; k++) cycle(4'hF, k % 4, 1'b0, 1'b0, 4'h0);
    cycle(4'hF, -1, 1'b0, 1'b0, 4'h0);       // 8 in flight, no grant
    cycle(4'hF, -1, 1'b0, 1'b0, 4'h0);       // issue register drained
    cycle(4'hF, -1, 1'b1, 1'b0, 4'h0);       // pop frees credit only next cycle
    cycle(4'hF, 0, 1'b0, 1'b0, 4'h0);        // credit back: requester 0 wins
    cycle(4'h0, -1, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 10; k++) cycle(4'h0, -1, 1'b1, 1'b0, 4'h0);

    // Streaming: grant and pop in the same cycle, pointers wrap
    for (int k = 0; k < 10; k++) cycle(4'hF, (1 + k) % 4, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) cycle(4'h0, -1, 1'b1, 1'b0, 4'h0);

    // Single operation from requester 2
    fixed_ops = 1'b1;
    req_a[2]  = 32'h3F80_0000;
    req_b[2]  = 32'h4000_0000;
    cycle(4'b0100, 2, 1'b0, 1'b0, 4'h0);
    cycle(4'b0000, -1, 1'b0, 1'b0, 4'h0);
    cycle(4'b0000, -1, 1'b1, 1'b0, 4'h0);   // returns 32'h40000000 on bit 2
    cycle(4'b0000, -1, 1'b0, 1'b0, 4'h0);
    fixed_ops = 1'b0;

    // Multiplier backpressure: issue register holds, no grants
    cycle(4'hF, 3, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) cycle(4'hF, -1, 1'b0, 1'b1, 4'h0);
    cycle(4'hF, 0, 1'b0, 1'b0, 4'h0);
    cycle(4'h0, -1, 1'b0, 1'b0, 4'h0);

    // Result backpressure on requester 3
    for (int k = 0; k < 3; k++) cycle(4'h0, -1, 1'b1, 1'b0, 4'b1000);
    cycle(4'h0, -1, 1'b1, 1'b0, 4'h0);
    cycle(4'h0, -1, 1'b1, 1'b0, 4'h0);
    check("drained", mul_pipe.size(), 0);

    // Stray result with empty FIFO
    iMUL_VALID = 1'b1;
    iMUL_DATA  = 32'hDEAD_BEEF;
    #1;
    check("stray_res_valid", oRES_VALID, 4'h0);
    check("stray_mul_busy", oMUL_BUSY, 1'b0);
    tick();
    iMUL_VALID = 1'b0;
    #1;
    check("stray_err", oERR, 1'b1);
    check("stray_inflight", oINFLIGHT, 0);
    exp_err = 1'b1;
    tick();

    // Leave one op in flight, then flush
    cycle(4'b0010, 1, 1'b0, 1'b0, 4'h0);
    cycle(4'b0000, -1, 1'b0, 1'b0, 4'h0);
    iREQ_VALID  = 4'hF;
    iRESET_SYNC = 1'b1;
    #1;
    check("flush_req_busy", oREQ_BUSY, 4'hF);
    tick();
    iRESET_SYNC = 1'b0;
    iREQ_VALID  = 4'h0;
    #1;
    check("flush_err", oERR, 1'b0);
    check("flush_inflight", oINFLIGHT, 0);
    check("flush_mul_valid", oMUL_VALID, 1'b0);
    check("flush_mul_a", oMUL_A, 32'h0);
    tick();
    mul_pipe.delete();
    iss_v        = 1'b0;
    exp_inflight = 0;
    exp_err      = 1'b0;
    cycle(4'hF, 0, 1'b0, 1'b0, 4'h0);       // rr pointer back at 0
    cycle(4'h0, -1, 1'b0, 1'b0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_float_arbiter.md
# mul_float_arbiter

Round-robin arbiter that shares one single-precision floating-point multiplier pipeline between four requesters. It registers the winning operand pair into the pipeline and records the winner's ID in an in-order tag FIFO. Returning results are routed to the originating requester. It sits between the client units and the multiplier top and uses the same valid/busy handshake as the multiplier stages.

## Interface
- DEPTH, 8: tag FIFO entries and the maximum number of in-flight operations. Must be a power of two, 2..32, and at least the multiplier pipeline occupancy.
- iCLOCK  in  1  clock
- inRESET  in  1  reset, asynchronous, active-low
- iRESET_SYNC  in  1  synchronous flush, same effect as reset
- iREQ_VALID  in  4  per-requester operation valid
- oREQ_BUSY  out  4  per-requester stall; bit i low means that requester's operands are taken this cycle
- iREQ_A, iREQ_B  in  4x32 each  per-requester IEEE-754 operands, packed [32*i+31:32*i]
- oMUL_VALID  out  1  operand valid to multiplier
- iMUL_BUSY  in  1  multiplier stall
- oMUL_A, oMUL_B  out  32 each  operands to multiplier
- iMUL_VALID  in  1  result valid from multiplier
- oMUL_BUSY  out  1  stall to multiplier output
- iMUL_DATA  in  32  result from multiplier
- oRES_VALID  out  4  one-hot result valid per requester
- iRES_BUSY  in  4  per-requester result stall
- oRES_DATA  out  32  result data, shared by all requesters
- oINFLIGHT  out  $clog2(DEPTH+1)  operations accepted and not yet returned
- oERR  out  1  sticky protocol error

## Operation
- Transfer rule on every interface: a transfer occurs when valid=1 and busy=0.
- **Issue register.** Holds {valid, A, B}. It can accept a new operation when it is empty or iMUL_BUSY=0.
- **Grant.** Grant is allowed when the issue register can accept, oINFLIGHT<DEPTH and iRESET_SYNC=0.
  - The winner is the first requester with iREQ_VALID=1, searching from rr_ptr upward, mod 4.
  - Only the winner's oREQ_BUSY bit is 0. All other bits are 1.
  - When no grant is allowed, oREQ_BUSY=4'hF.
- **On grant:**
  - Load the issue register with the winner's operands.
  - Push the winner's ID (2 bits) into the tag FIFO.
  - Set rr_ptr = winner+1, mod 4.
  - rr_ptr does not change in cycles with no grant.
- **Issue register drain.** When iMUL_BUSY=0 and there is no new grant, the issue register's valid clears.
- **Return path.** The tag at the head of the FIFO selects the requester.
  - oRES_VALID = iMUL_VALID one-hot at bit head.
  - oRES_DATA = iMUL_DATA.
  - oMUL_BUSY = iRES_BUSY[head] when iMUL_VALID=1, otherwise 0.
  - On a result transfer (iMUL_VALID && !oMUL_BUSY), pop the FIFO.
- **In-flight count.** oINFLIGHT increments on grant and decrements on pop. Grant and pop in the same cycle leave it unchanged.
- **Tag FIFO.** Read and write pointers are log2(DEPTH)+1 bits. Wrap-around uses the MSB compare. Empty when pointers are equal.
- **Errors.** oERR sets when iMUL_VALID=1 while the FIFO is empty. In that case:
  - oRES_VALID=0 and oMUL_BUSY=0, so the stray result is discarded.
  - No pop occurs.
  - oERR clears only on reset or flush.
- **Full FIFO.** Push is impossible when full because the grant is gated by oINFLIGHT<DEPTH. A simultaneous pop frees no credit until the next cycle.

## Timing
- Values on reset or iRESET_SYNC:
  - oMUL_VALID=0, oRES_VALID=0, oINFLIGHT=0, oERR=0.
  - oMUL_A and oMUL_B = 0.
  - rr_ptr=0, FIFO empty.
  - oREQ_BUSY=4'hF during flush.
- A flush mid-operation discards in-flight tags. The team flushes the multiplier in the same cycle.
- Latency: a grant in cycle t produces oMUL_VALID=1 with the operands in cycle t+1. Operands are held while iMUL_BUSY=1.
- Throughput: one grant per cycle while iMUL_BUSY=0 and credits are available.
- The return path is combinational, with zero cycles of added latency. oRES_DATA is valid only with its oRES_VALID bit.
- oREQ_BUSY is combinational from iREQ_VALID, iMUL_BUSY, oINFLIGHT and rr_ptr.

## Test plan
- **Single operation.** Requester 2 sends A=32'h3F800000, B=32'h40000000.
  - oREQ_BUSY=4'b1011 in the grant cycle.
  - The next cycle shows oMUL_VALID=1 and oMUL_A=32'h3F800000.
  - When the model returns 32'h40000000, oRES_VALID=4'b0100 and oINFLIGHT goes 0→1→0.
- **Round-robin fairness.** All four requesters hold valid continuously with iMUL_BUSY=0.
  - Grant order is 0,1,2,3,0,1,…
  - Results return in the same order, each on the correct oRES_VALID bit.
- **Credit limit.** DEPTH=8 and no results returned.
  - Exactly 8 grants occur, oINFLIGHT=8, and oREQ_BUSY=4'hF.
  - One result pop re-enables a grant on the following cycle.
  - The 16-op wrap-around completes with correct routing.
- **Backpressure.**
  - iMUL_BUSY=1 for 5 cycles: issue-register contents are stable and no grants occur.
  - iRES_BUSY[head]=1: oMUL_BUSY=1, no pop, and oRES_VALID stays asserted until the release.
- **Simultaneous grant and pop.** A grant and a pop occur in the same cycle: oINFLIGHT is unchanged and the FIFO order is preserved.
- **Error and flush.**
  - iMUL_VALID=1 with the FIFO empty: oERR=1 and oRES_VALID=0.
  - Then iRESET_SYNC for 1 cycle: oERR=0, oINFLIGHT=0, oMUL_VALID=0, and rr_ptr=0, so requester 0 wins the next contention.
